mainmem_rv: RTL

Parametrised successor to the processor's main data memory. It adds a valid/ready request port, a configurable pipelined read latency and a hardware clear sequencer that zeroes one word per cycle after reset. Sits between the load/store stage and the word-addressed storage array, and is single-clocked on `clk`.

---
 rtl/mainmem_rv.sv | 116 +++++++++++
 1 files changed

// File: rtl/mainmem_rv.sv
// Main data memory: valid/ready request port, pipelined reads, post-reset clear.
// Optional per-byte write merge is enabled by defining MAINMEM_BYTE_WRITE_EN.
module mainmem_rv #(
  parameter int WORD_SIZE    = 32,
  parameter int ADDR_BITS    = 5,
  parameter int DEPTH        = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ADDR_BITS-1:0]   req_addr,
  input  logic [WORD_SIZE-1:0]   req_wdata,
  input  logic [WORD_SIZE/8-1:0] req_be,
  output logic                   resp_valid,
  output logic [WORD_SIZE-1:0]   resp_rdata,
  output logic                   busy_clear
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0]        ptr_q;
  logic [WORD_SIZE-1:0] mem [DEPTH];

  logic                 accept;
  logic                 rd_acc;
  logic                 in_range;
  logic                 last_word;
  logic [IW-1:0]        idx;
  logic [WORD_SIZE-1:0] rd_word;
  logic [WORD_SIZE-1:0] wr_word;

  logic [READ_LATENCY-1:0] vld_q;
  logic [WORD_SIZE-1:0]    dat_q [READ_LATENCY];

  assign idx       = req_addr[IW-1:0];
  assign in_range  = {1'b0, req_addr} < (ADDR_BITS+1)'(DEPTH);
  assign last_word = ptr_q == IW'(DEPTH - 1);
  assign accept    = req_valid & req_ready;
  assign rd_acc    = accept & ~req_write;
  assign rd_word   = in_range ? mem[idx] : '0;

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    busy_clear = 1'b0;
    unique case (state_q)
      CLEAR: begin
        busy_clear = 1'b1;
        if (last_word) state_d = READY;
      end
      READY: req_ready = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= CLEAR;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset)                ptr_q <= '0;
    else if (state_q == CLEAR) ptr_q <= ptr_q + 1'b1;
  end

`ifdef MAINMEM_BYTE_WRITE_EN
  // Unselected bytes are taken from the current word
  always_comb begin
    wr_word = rd_word;
    for (int b = 0; b < WORD_SIZE/8; b++) begin
      if (req_be[b]) wr_word[8*b +: 8] = req_wdata[8*b +: 8];
    end
  end
`else
  logic unused_be;
  assign unused_be = ^req_be;
  assign wr_word   = req_wdata;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      if (state_q == CLEAR)
        mem[ptr_q] <= '0;
      else if (accept && req_write && in_range)
        mem[idx] <= wr_word;
    end
  end

  // Data stages only load behind a valid so the output holds between pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= rd_acc;
      if (rd_acc) dat_q[0] <= rd_word;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign resp_valid = vld_q[READ_LATENCY-1];
  assign resp_rdata = dat_q[READ_LATENCY-1];

endmodule
